// File: rtl/prog_loader_if.sv
// Byte-stream receive handshake, instruction-memory write port and loader status.
// master drives the byte stream; slave is the loader.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 14
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_wdata, mem_we, core_reset, busy, done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_wdata, mem_we, core_reset, busy, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream programmer for the instruction memory; holds the core in reset while loading.
// Define LOADER_CHECKSUM_EN to require and verify a trailing checksum byte per frame.
module prog_loader #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned DATA_W     = 14,
    parameter logic [7:0]  START_BYTE = 8'hA5
) (
    input logic          clk,
    input logic          reset,
    prog_loader_if.slave bus
);
    localparam int unsigned CntHiW = ADDR_W - 8;
    localparam int unsigned HiW    = DATA_W - 8;

    typedef enum logic [3:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StDataHi,
        StDataLo,
        StWrite,
`ifdef LOADER_CHECKSUM_EN
        StCheck,
`endif
        StDone,
        StError
    } state_e;

    // State entered once the last word (or an empty count) has been handled.
`ifdef LOADER_CHECKSUM_EN
    localparam state_e StFinal = StCheck;
`else
    localparam state_e StFinal = StDone;
`endif

    state_e            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [HiW-1:0]    hi_q, hi_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rx_ready_q, mem_we_q, core_reset_q, busy_q, done_q, error_q;

    logic              accept;
    logic              start_accept;
    logic [ADDR_W-1:0] word_next;
    logic [ADDR_W-1:0] cnt_n;

    assign accept       = bus.rx_valid && rx_ready_q;
    assign start_accept = accept && (bus.rx_data == START_BYTE)
                          && (state_q inside {StIdle, StDone, StError});
    assign word_next    = word_cnt_q + ADDR_W'(1);
    assign cnt_n        = {cnt_hi_q[CntHiW-1:0], bus.rx_data};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (start_accept) begin
            chk_d = '0;
        end else if (accept && (state_q inside {StCntHi, StCntLo, StDataHi, StDataLo})) begin
            chk_d = chk_q + bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        mem_addr_d  = mem_addr_q;
        hi_d        = hi_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_accept) begin
                    state_d    = StCntHi;
                    word_cnt_d = '0;
                    mem_addr_d = '0;
                end
            end
            StCntHi: begin
                if (accept) begin
                    cnt_hi_d = bus.rx_data;
                    state_d  = StCntLo;
                end
            end
            StCntLo: begin
                if (accept) begin
                    n_d = cnt_n;
                    if (cnt_hi_q[7:CntHiW] != '0) begin
                        state_d = StError;
                    end else if (cnt_n == '0) begin
                        state_d = StFinal;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (accept) begin
                    hi_d    = bus.rx_data[HiW-1:0];
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (accept) begin
                    // Address and data are latched here and held until the next word.
                    mem_addr_d  = word_cnt_q;
                    mem_wdata_d = {hi_q, bus.rx_data};
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                word_cnt_d = word_next;
                state_d    = (word_next == n_q) ? StFinal : StDataHi;
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (accept) begin
                    state_d = (bus.rx_data == chk_q) ? StDone : StError;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_hi_q     <= '0;
            n_q          <= '0;
            word_cnt_q   <= '0;
            mem_addr_q   <= '0;
            hi_q         <= '0;
            mem_wdata_q  <= '0;
            rx_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            mem_addr_q   <= mem_addr_d;
            hi_q         <= hi_d;
            mem_wdata_q  <= mem_wdata_d;
            rx_ready_q   <= (state_d != StWrite);
            mem_we_q     <= (state_d == StWrite);
            core_reset_q <= !(state_d inside {StIdle, StDone});
            busy_q       <= !(state_d inside {StIdle, StDone, StError});
            done_q       <= (state_d == StDone);
            error_q      <= (state_d == StError);
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.core_reset = core_reset_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus random frames against a stream parser.
module tb_prog_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(13), .DATA_W(14)) bus ();

    prog_loader #(.ADDR_W(13), .DATA_W(14), .START_BYTE(8'hA5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  stream[$];
    logic [12:0] exp_addr[$];
    logic [13:0] exp_data[$];
    logic [12:0] log_addr[$];
    logic [13:0] log_data[$];
    logic        exp_done, exp_error, exp_core;
    int unsigned rdy_viol = 0;

    // Write log and handshake watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_we) begin
                log_addr.push_back(bus.mem_addr);
                log_data.push_back(bus.mem_wdata);
            end
            if (bus.rx_ready === bus.mem_we) rdy_viol++;
        end
    end

    task automatic clear_all();
        stream.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap_pct);
        int unsigned guard = 0;
        while ($urandom_range(99) < gap_pct) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_checks++;
        if (guard >= 50) begin
            n_fail++;
            $display("FAIL handshake_timeout: rx_ready=%b after %0d cycles, required 1", bus.rx_ready,
                     guard);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_stream(input int unsigned first, input int unsigned gap_pct);
        for (int k = int'(first); k < stream.size(); k++) send_byte(stream[k], gap_pct);
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_byte();
        return ($urandom_range(7) == 0) ? 8'hA5 : 8'($urandom);
    endfunction

    task automatic add_frame(input int unsigned n, input bit bad);
        logic [7:0] h, l, b, sum;
        h = 8'(n >> 8);
        l = 8'(n);
        stream.push_back(8'hA5);
        stream.push_back(h);
        stream.push_back(l);
        sum = 8'(h + l);
        for (int unsigned k = 0; k < 2 * n; k++) begin
            b = rand_byte();
            stream.push_back(b);
            sum = 8'(sum + b);
        end
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(bad ? 8'(sum + 8'd1) : sum);
`else
        if (bad) stream.push_back(8'h3C);
`endif
    endtask

    // Reference: walk the byte stream frame by frame using frame layout arithmetic.
    task automatic run_model();
        int         i;
        int         n;
        logic [7:0] h, l, sum;
        i = 0;
        exp_addr.delete();
        exp_data.delete();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_core  = 1'b0;
        while (i < stream.size()) begin
            if (stream[i] != 8'hA5 || i + 2 >= stream.size()) begin
                i++;
                continue;
            end
            exp_done  = 1'b0;
            exp_error = 1'b0;
            exp_core  = 1'b1;
            h = stream[i+1];
            l = stream[i+2];
            sum = 8'(h + l);
            i += 3;
            if (h[7:5] != 3'd0) begin
                exp_error = 1'b1;
                continue;
            end
            n = int'({h[4:0], l});
            for (int k = 0; k < n; k++) begin
                h = stream[i];
                l = stream[i+1];
                i += 2;
                sum = 8'(sum + h + l);
                exp_addr.push_back(13'(k));
                exp_data.push_back({h[5:0], l});
            end
`ifdef LOADER_CHECKSUM_EN
            exp_done  = (stream[i] == sum);
            exp_error = !exp_done;
            i++;
`else
            exp_done = 1'b1;
`endif
            exp_core = !exp_done;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(2);
        n_checks += 8;
        if (bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        if (bus.mem_addr !== 13'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        if (bus.mem_wdata !== 14'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        if (bus.core_reset !== 1'b0) begin n_fail++; $display("FAIL reset_core_reset: got %b want 0", bus.core_reset); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (bus.error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", bus.error); end
        reset = 1'b0;
    endtask

    task automatic test_good_frame(input int unsigned gap_pct, input bit noise);
        clear_all();
        if (noise) stream = '{8'h00, 8'hFF, 8'h5A};
        stream.push_back(8'hA5);
        stream.push_back(8'h00);
        stream.push_back(8'h02);
        stream.push_back(8'h3F);
        stream.push_back(8'hFF);
        stream.push_back(8'h12);
        stream.push_back(8'h34);
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(8'h86);
`endif
        for (int k = 0; k < stream.size(); k++) begin
            send_byte(stream[k], gap_pct);
            if (stream[k] == 8'hA5) begin
                n_checks += 3;
                if (bus.core_reset !== 1'b1) begin n_fail++; $display("FAIL good_core_reset_set: got %b want 1", bus.core_reset); end
                if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL good_busy: got %b want 1", bus.busy); end
                if (bus.done !== 1'b0) begin n_fail++; $display("FAIL good_done_cleared: got %b want 0", bus.done); end
            end
        end
        wait_cycles(3);
        n_checks += 5;
        if (log_addr.size() != 2) begin
            n_fail++;
            $display("FAIL good_write_count: got %0d want 2", log_addr.size());
        end else if (log_addr[0] !== 13'd0 || log_data[0] !== 14'h3FFF ||
                     log_addr[1] !== 13'd1 || log_data[1] !== 14'h1234) begin
            n_fail++;
            $display("FAIL good_writes: got %h@%h %h@%h want 3fff@0000 1234@0001", log_data[0],
                     log_addr[0], log_data[1], log_addr[1]);
        end
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL good_done: got %b want 1", bus.done); end
        if (bus.error !== 1'b0) begin n_fail++; $display("FAIL good_error: got %b want 0", bus.error); end
        if (bus.core_reset !== 1'b0) begin n_fail++; $display("FAIL good_core_reset_clr: got %b want 0", bus.core_reset); end
        if (rdy_viol != 0) begin n_fail++; $display("FAIL ready_vs_write: got %0d cycles with rx_ready==mem_we want 0", rdy_viol); end
    endtask

    task automatic test_bad_checksum();
`ifdef LOADER_CHECKSUM_EN
        clear_all();
        stream = '{8'hA5, 8'h00, 8'h02, 8'h3F, 8'hFF, 8'h12, 8'h34, 8'h87};
        send_stream(0, 0);
        n_checks += 4;
        if (bus.error !== 1'b1) begin n_fail++; $display("FAIL badchk_error: got %b want 1", bus.error); end
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL badchk_done: got %b want 0", bus.done); end
        if (bus.core_reset !== 1'b1) begin n_fail++; $display("FAIL badchk_core_reset: got %b want 1", bus.core_reset); end
        if (log_addr.size() != 2) begin n_fail++; $display("FAIL badchk_write_count: got %0d want 2", log_addr.size()); end
`endif
    endtask

    task automatic test_empty_frame();
        clear_all();
        stream = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(8'h00);
`endif
        send_stream(0, 0);
        n_checks += 3;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL empty_done_latency: got %b want 1", bus.done); end
        if (bus.core_reset !== 1'b0) begin n_fail++; $display("FAIL empty_core_reset: got %b want 0", bus.core_reset); end
        wait_cycles(2);
        if (log_addr.size() != 0) begin n_fail++; $display("FAIL empty_writes: got %0d want 0", log_addr.size()); end
    endtask

    task automatic test_invalid_count();
        clear_all();
        stream = '{8'hA5, 8'h20, 8'h00};
        send_stream(0, 0);
        n_checks += 3;
        if (bus.error !== 1'b1) begin n_fail++; $display("FAIL badcnt_error: got %b want 1", bus.error); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL badcnt_busy: got %b want 0", bus.busy); end
        wait_cycles(2);
        if (log_addr.size() != 0) begin n_fail++; $display("FAIL badcnt_writes: got %0d want 0", log_addr.size()); end
        clear_all();
        stream = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h2A};
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(8'h2B);
`endif
        send_stream(0, 0);
        wait_cycles(3);
        n_checks += 3;
        if (log_addr.size() != 1 || log_addr[0] !== 13'd0 || log_data[0] !== 14'h002A) begin
            n_fail++;
            $display("FAIL recover_write: got %0d writes, first %h@%h want 002a@0000", log_addr.size(),
                     log_data[0], log_addr[0]);
        end
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL recover_done: got %b want 1", bus.done); end
        if (bus.error !== 1'b0) begin n_fail++; $display("FAIL recover_error: got %b want 0", bus.error); end
    endtask

    task automatic test_reset_midload();
        clear_all();
        stream = '{8'hA5, 8'h00, 8'h02, 8'h3F};
        send_stream(0, 0);
        n_checks += 2;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midload_busy: got %b want 1", bus.busy); end
        if (bus.core_reset !== 1'b1) begin n_fail++; $display("FAIL midload_core_reset: got %b want 1", bus.core_reset); end
        test_reset();
        test_good_frame(30, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            clear_all();
            if (r == 0) add_frame($urandom_range(300, 256), 1'b0);
            for (int f = 0; f < 3; f++) add_frame($urandom_range(4, 1), (f == 1) && (r[0] == 1'b1));
            if (r == 3) stream.push_back(8'h77);
            run_model();
            send_stream(0, $urandom_range(60));
            wait_cycles(4);
            n_checks++;
            if (log_addr.size() != exp_addr.size()) begin
                n_fail++;
                $display("FAIL b2b_write_count round %0d: got %0d want %0d", r, log_addr.size(),
                         exp_addr.size());
            end else begin
                for (int k = 0; k < log_addr.size(); k++) begin
                    n_checks++;
                    if (log_addr[k] !== exp_addr[k] || log_data[k] !== exp_data[k]) begin
                        n_fail++;
                        $display("FAIL b2b_write round %0d idx %0d: got %h@%h want %h@%h", r, k,
                                 log_data[k], log_addr[k], exp_data[k], exp_addr[k]);
                    end
                end
            end
            n_checks += 3;
            if (bus.done !== exp_done) begin n_fail++; $display("FAIL b2b_done round %0d: got %b want %b", r, bus.done, exp_done); end
            if (bus.error !== exp_error) begin n_fail++; $display("FAIL b2b_error round %0d: got %b want %b", r, bus.error, exp_error); end
            if (bus.core_reset !== exp_core) begin n_fail++; $display("FAIL b2b_core_reset round %0d: got %b want %b", r, bus.core_reset, exp_core); end
        end
        n_checks++;
        if (rdy_viol != 0) begin n_fail++; $display("FAIL b2b_ready_vs_write: got %0d want 0", rdy_viol); end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_good_frame(0, 1'b0);
        test_bad_checksum();
        test_empty_frame();
        test_invalid_count();
        test_good_frame(50, 1'b1);
        test_reset_midload();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
